sram_like_responder: RTL and testbench
======================================

// Module: sram_like_responder
// PURPOSE
//  Responder (slave) end of the CPU's SRAM-like request/response interface (req/wr/size/addr/wdata ->
//  addr_ok/data_ok/rdata). Services requests against a 1-cycle synchronous SRAM port.
//  Provides programmable fixed latency plus optional LFSR-driven addr_ok stalls and data_ok delays.
//  Used in the SoC/test wrapper to stress the mips core's inst/data request handshakes.
// PARAMETERS
//  DEPTH       4        max outstanding requests (accepted, data_ok not yet given); >=1
//  LATENCY     0        extra cycles beyond minimum before data_ok (0 = data_ok in cycle after accept)
//  RAND_STALL  0        1: pseudo-randomly withhold addr_ok (~25% of cycles)
//  RAND_DELAY  0        1: add lfsr[4:2] (0..7) extra cycles to each response's delay
//  SEED        8'hA5    LFSR reset value; must be nonzero
// PORTS
//  clk         in   1   clock
//  rst         in   1   asynchronous reset, active-high
//  req         in   1   request valid
//  wr          in   1   1 = write, 0 = read
//  size        in   2   0 byte, 1 half, 2 word (3 treated as word)
//  addr        in   32  byte address
//  wdata       in   32  write data, lane-aligned by requester
//  addr_ok     out  1   request accepted this cycle
//  data_ok     out  1   oldest outstanding request completes this cycle (no backpressure)
//  rdata       out  32  read data when data_ok; 32'h0 for write completions
//  sram_en     out  1   SRAM access strobe
//  sram_wen    out  4   SRAM byte write enables
//  sram_addr   out  32  {addr[31:2],2'b00}
//  sram_wdata  out  32  wdata passthrough
//  sram_rdata  in   32  SRAM read data, valid cycle after sram_en
// BEHAVIOUR
//  - Reset: FIFO, occupancy, stage-1 register cleared; LFSR=SEED; addr_ok/data_ok/sram_en=0, wen=0, rdata=0.
//  - occ = FIFO count + stage-1 valid. Accept: addr_ok = req & ~rst & (occ<DEPTH) & ~stall.
//    occ counted before same-cycle pop (a freed slot usable next cycle).
//  - stall = RAND_STALL & lfsr[0] & lfsr[1]. LFSR 8-bit Fibonacci x^8+x^6+x^5+x^4+1, steps every cycle.
//  - Accept cycle t: sram_en=1; sram_wen = wr ? (size0: 4'b0001<<addr[1:0]; size1: 4'b0011<<addr[1:0];
//    else 4'b1111) : 0. No access (en=0, wen=0) when not accepted. Misaligned sizes are not checked.
//  - Stage-1 register at t+1: {valid, wr, dly}; dly = LATENCY + (RAND_DELAY ? lfsr[4:2] at t : 0).
//  - t+1: if FIFO empty & dly==0 -> bypass: data_ok=1, rdata = wr ? 0 : sram_rdata, no push.
//    Otherwise push {wr ? 0 : sram_rdata, wr, dly} into FIFO.
//  - Each FIFO entry's counter decrements every cycle, saturating at 0. data_ok = head valid &
//    head counter==0; pop same cycle. Responses strictly in acceptance order; a zero-delay
//    younger entry waits behind the head.
//  - Bypass only while FIFO empty, so ordering holds. Push and pop in the same cycle: count unchanged.
//  - Full (occ==DEPTH): addr_ok=0 regardless of req; SRAM idle.
//  - Pointers wrap modulo DEPTH; counter width clog2(LATENCY+8)+1.
//  - rst mid-operation: all in-flight requests dropped; no data_ok for them, ever.
//  - data_ok and rdata are combinational from registered state plus sram_rdata (bypass path).
//    addr_ok is combinational from req.
// STRUCTURE
//  - Shared package sram_like_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), function byte_en(size, addr[1:0]),
//    response entry struct {rdata, wr, cnt}.
//  - Sub-module sram_like_resp_fifo: DEPTH-entry in-order FIFO with per-entry saturating delay counters,
//    head_ready output. Top holds accept logic, LFSR, stage-1 register and bypass mux.
// TESTING
//  1 Defaults; read size2 addr 0x1000_0004, sram_rdata=0xDEADBEEF at t+1 -> addr_ok@t, sram_addr 0x1000_0004,
//    wen 0, data_ok@t+1 with rdata 0xDEADBEEF.
//  2 Byte write addr 0x8000_0003 wdata 0xAA000000 -> wen 4'b1000, sram_addr 0x8000_0000;
//    half write 0x...02 -> wen 4'b1100; data_ok@t+1, rdata 0.
//  3 LATENCY=3; four back-to-back reads t..t+3 -> data_ok at t+4..t+7; rdata in issue order.
//  4 DEPTH=2, LATENCY=5, req held high -> accepts @t, t+1. First data_ok@t+6; third addr_ok@t+7.
//  5 RAND_STALL=RAND_DELAY=1, 2000 random mixed reqs vs memory model -> every read matches,
//    #data_ok==#addr_ok, order preserved, occ never >DEPTH.
//  6 Two reads outstanding (LATENCY=4), rst pulsed mid-flight -> outputs 0 during rst;
//    no data_ok afterward; next read completes normally.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the SRAM-like responder.
// Size encodings, byte-lane enables and the response entry bundle.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int RESP_CNT_W = 16;

    typedef struct packed {
        logic [31:0]           rdata;
        logic                  wr;
        logic [RESP_CNT_W-1:0] cnt;
    } resp_t;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_like_if.sv
// CPU-side SRAM-like request/response bundle.
// The core is the master; the responder is the slave.
interface sram_like_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order response FIFO with per-entry saturating delay counters.
// The head is ready once its counter has run down to zero.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  resp_t         push_entry,
    input  logic          pop,
    output logic [31:0]   head_rdata,
    output logic          head_wr,
    output logic          head_ready,
    output logic [NW-1:0] count
);

    logic [31:0]   rdata_q [DEPTH];
    logic          wr_q    [DEPTH];
    logic [CW-1:0] cnt_q   [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push_nz;
    logic [CW-1:0] push_cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The push cycle already counts as one elapsed delay cycle.
    always_comb begin
        push_nz  = |push_entry.cnt;
        push_cnt = '0;
        if (push_nz)
            push_cnt = push_entry.cnt[CW-1:0] - 1'b1;
    end

    // Storage, pointers, occupancy and per-entry countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdata_q[i] <= '0;
                wr_q[i]    <= 1'b0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - 1'b1;
            end
            if (push) begin
                rdata_q[wptr] <= push_entry.rdata;
                wr_q[wptr]    <= push_entry.wr;
                cnt_q[wptr]   <= push_cnt;
                wptr          <= nxt(wptr);
            end
            if (pop)
                rptr <= nxt(rptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Head view for the completion path.
    always_comb begin
        head_rdata = rdata_q[rptr];
        head_wr    = wr_q[rptr];
        head_ready = (count != '0) && (cnt_q[rptr] == '0);
    end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like bus in front of a 1-cycle SRAM.
// Programmable latency plus optional LFSR-driven stalls and delays.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter int         LATENCY    = 0,
    parameter int         RAND_STALL = 0,
    parameter int         RAND_DELAY = 0,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    sram_like_if.slave  bus,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int CW = $clog2(LATENCY + 8) + 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + 2);

    logic [7:0]    lfsr;
    logic          stall;
    logic          accept;
    logic [OW-1:0] occ;
    logic [CW-1:0] dly_d;
    logic          s1_valid;
    logic          s1_wr;
    logic [CW-1:0] s1_dly;
    logic [NW-1:0] fifo_count;
    logic          bypass;
    logic          push;
    logic          head_ready;
    logic          head_wr;
    logic [31:0]   head_rdata;
    resp_t         push_entry;

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Accept decision and the SRAM access it launches.
    always_comb begin
        stall    = (RAND_STALL != 0) && lfsr[0] && lfsr[1];
        occ      = OW'(fifo_count) + OW'(s1_valid);
        accept   = bus.req && !rst && (occ < OW'(DEPTH)) && !stall;
        dly_d    = CW'(LATENCY);
        if (RAND_DELAY != 0)
            dly_d = dly_d + CW'(lfsr[4:2]);
        bus.addr_ok = accept;
        sram_en     = accept;
        sram_wen    = '0;
        if (accept && bus.wr)
            sram_wen = byte_en(bus.size, bus.addr[1:0]);
        sram_addr  = {bus.addr[31:2], 2'b00};
        sram_wdata = bus.wdata;
    end

    // Stage-1 tracks the access whose SRAM data arrives this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_wr    <= 1'b0;
            s1_dly   <= '0;
        end else begin
            s1_valid <= accept;
            s1_wr    <= bus.wr;
            s1_dly   <= dly_d;
        end
    end

    // Bypass only when nothing older is queued, keeping order.
    always_comb begin
        bypass           = s1_valid && (fifo_count == '0) && (s1_dly == '0);
        push             = s1_valid && !bypass;
        push_entry.rdata = s1_wr ? 32'h0 : sram_rdata;
        push_entry.wr    = s1_wr;
        push_entry.cnt   = RESP_CNT_W'(s1_dly);
    end

    // Completion mux: bypassed stage-1 or the FIFO head.
    always_comb begin
        bus.data_ok = 1'b0;
        bus.rdata   = '0;
        if (bypass) begin
            bus.data_ok = 1'b1;
            bus.rdata   = s1_wr ? 32'h0 : sram_rdata;
        end else if (head_ready) begin
            bus.data_ok = 1'b1;
            bus.rdata   = head_wr ? 32'h0 : head_rdata;
        end
    end

    sram_like_resp_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (head_ready),
        .head_rdata (head_rdata),
        .head_wr    (head_wr),
        .head_ready (head_ready),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed cases on several
// configurations plus a randomized run against a memory model.
module tb_sram_like_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sram_like_if ia ();
    sram_like_if ib ();
    sram_like_if ic ();
    sram_like_if id ();
    sram_like_if ie ();

    logic        a_en, b_en, c_en, d_en, e_en;
    logic [3:0]  a_wen, b_wen, c_wen, d_wen, e_wen;
    logic [31:0] a_addr, b_addr, c_addr, d_addr, e_addr;
    logic [31:0] a_wd, b_wd, c_wd, d_wd, e_wd;
    logic [31:0] a_rd, b_rd, c_rd, d_rd, e_rd;

    sram_like_responder u_a (
        .clk(clk), .rst(rst), .bus(ia),
        .sram_en(a_en), .sram_wen(a_wen), .sram_addr(a_addr),
        .sram_wdata(a_wd), .sram_rdata(a_rd)
    );

    sram_like_responder #(.LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .bus(ib),
        .sram_en(b_en), .sram_wen(b_wen), .sram_addr(b_addr),
        .sram_wdata(b_wd), .sram_rdata(b_rd)
    );

    sram_like_responder #(.DEPTH(2), .LATENCY(5)) u_c (
        .clk(clk), .rst(rst), .bus(ic),
        .sram_en(c_en), .sram_wen(c_wen), .sram_addr(c_addr),
        .sram_wdata(c_wd), .sram_rdata(c_rd)
    );

    sram_like_responder #(.RAND_STALL(1), .RAND_DELAY(1)) u_d (
        .clk(clk), .rst(rst), .bus(id),
        .sram_en(d_en), .sram_wen(d_wen), .sram_addr(d_addr),
        .sram_wdata(d_wd), .sram_rdata(d_rd)
    );

    sram_like_responder #(.LATENCY(4)) u_e (
        .clk(clk), .rst(rst), .bus(ie),
        .sram_en(e_en), .sram_wen(e_wen), .sram_addr(e_addr),
        .sram_wdata(e_wd), .sram_rdata(e_rd)
    );

    // 1-cycle synchronous SRAM behind the randomized instance.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= 32'hC0DE_0000 | 32'(i);
            d_rd <= '0;
        end else if (d_en) begin
            d_rd <= mem[d_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (d_wen[b])
                    mem[d_addr[7:2]][8*b +: 8] <= d_wd[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [31:0] refm [64];
    logic [31:0] expq [$];
    int          acc;
    int          dok;

    task automatic d_observe();
        logic [31:0] e;
        logic [3:0]  ew;
        int          idx, st, nb;
        if (id.data_ok) begin
            dok++;
            chk("t5_qnonempty", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("t5_rdata", id.rdata, e);
            end
        end
        if (id.addr_ok) begin
            acc++;
            idx = int'(id.addr[7:2]);
            if (!id.wr) begin
                expq.push_back(refm[idx]);
            end else begin
                nb = (id.size == 2'd0) ? 1 : (id.size == 2'd1) ? 2 : 4;
                st = (nb == 4) ? 0 : int'(id.addr[1:0]);
                ew = '0;
                for (int b = 0; b < 4; b++) begin
                    if (b >= st && b < st + nb) begin
                        ew[b] = 1'b1;
                        refm[idx][8*b +: 8] = id.wdata[8*b +: 8];
                    end
                end
                chk("t5_wen", 32'(d_wen), 32'(ew));
                expq.push_back(32'h0);
            end
        end
        chk("t5_occ", 32'((acc - dok) <= 4), 32'd1);
    endtask

    initial begin
        ia.req = 1'b1; ia.wr = 1'b0; ia.size = 2'd2;
        ia.addr = 32'h0; ia.wdata = 32'h0;
        ib.req = 1'b0; ib.wr = 1'b0; ib.size = 2'd2;
        ib.addr = 32'h0; ib.wdata = 32'h0;
        ic.req = 1'b0; ic.wr = 1'b0; ic.size = 2'd2;
        ic.addr = 32'h0; ic.wdata = 32'h0;
        id.req = 1'b0; id.wr = 1'b0; id.size = 2'd2;
        id.addr = 32'h0; id.wdata = 32'h0;
        ie.req = 1'b0; ie.wr = 1'b0; ie.size = 2'd2;
        ie.addr = 32'h0; ie.wdata = 32'h0;
        a_rd = '0; b_rd = '0; c_rd = '0; e_rd = '0;

        // reset state, with a request pending on u_a
        mid();
        chk("rst_aok", 32'(ia.addr_ok), 32'd0);
        chk("rst_dok", 32'(ia.data_ok), 32'd0);
        chk("rst_en", 32'(a_en), 32'd0);
        chk("rst_wen", 32'(a_wen), 32'd0);
        chk("rst_rdata", ia.rdata, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        ia.req = 1'b0;

        // test 1: word read, data in the cycle after accept
        tick();
        ia.req = 1'b1; ia.wr = 1'b0; ia.size = 2'd2;
        ia.addr = 32'h1000_0004;
        mid();
        chk("t1_aok", 32'(ia.addr_ok), 32'd1);
        chk("t1_en", 32'(a_en), 32'd1);
        chk("t1_saddr", a_addr, 32'h1000_0004);
        chk("t1_wen", 32'(a_wen), 32'd0);
        chk("t1_dok0", 32'(ia.data_ok), 32'd0);
        tick();
        ia.req = 1'b0;
        a_rd = 32'hDEAD_BEEF;
        mid();
        chk("t1_dok", 32'(ia.data_ok), 32'd1);
        chk("t1_rdata", ia.rdata, 32'hDEAD_BEEF);

        // test 2: byte write then half write
        tick();
        ia.req = 1'b1; ia.wr = 1'b1; ia.size = 2'd0;
        ia.addr = 32'h8000_0003; ia.wdata = 32'hAA00_0000;
        a_rd = 32'h5555_5555;
        mid();
        chk("t2b_aok", 32'(ia.addr_ok), 32'd1);
        chk("t2b_wen", 32'(a_wen), 32'b1000);
        chk("t2b_saddr", a_addr, 32'h8000_0000);
        chk("t2b_wdata", a_wd, 32'hAA00_0000);
        tick();
        ia.req = 1'b0;
        a_rd = 32'h1234_5678;
        mid();
        chk("t2b_dok", 32'(ia.data_ok), 32'd1);
        chk("t2b_rdata", ia.rdata, 32'h0);
        tick();
        ia.req = 1'b1; ia.wr = 1'b1; ia.size = 2'd1;
        ia.addr = 32'h8000_0002; ia.wdata = 32'hBBBB_0000;
        mid();
        chk("t2h_wen", 32'(a_wen), 32'b1100);
        chk("t2h_saddr", a_addr, 32'h8000_0000);
        tick();
        ia.req = 1'b0;
        a_rd = 32'h8765_4321;
        mid();
        chk("t2h_dok", 32'(ia.data_ok), 32'd1);
        chk("t2h_rdata", ia.rdata, 32'h0);
        tick();
        mid();
        chk("t2_idle_dok", 32'(ia.data_ok), 32'd0);
        chk("t2_idle_en", 32'(a_en), 32'd0);

        // test 3: LATENCY=3, four back-to-back reads
        for (int c = 0; c < 8; c++) begin
            tick();
            ib.req = (c < 4);
            ib.addr = 32'h100 + 32'(4 * c);
            b_rd = (c >= 1 && c <= 4) ? 32'h1111_0000 + 32'(c - 1)
                                      : 32'hFFFF_FFFF;
            mid();
            chk("t3_aok", 32'(ib.addr_ok), 32'(c < 4));
            chk("t3_dok", 32'(ib.data_ok), 32'(c >= 4));
            if (c >= 4)
                chk("t3_rdata", ib.rdata, 32'h1111_0000 + 32'(c - 4));
        end
        ib.req = 1'b0;

        // test 4: DEPTH=2, LATENCY=5, req held high
        for (int c = 0; c < 8; c++) begin
            tick();
            ic.req = 1'b1;
            ic.addr = 32'h40 + 32'(4 * c);
            c_rd = (c == 1) ? 32'hA1 : (c == 2) ? 32'hA2 : 32'h0;
            mid();
            chk("t4_aok", 32'(ic.addr_ok), 32'(c < 2 || c == 7));
            chk("t4_en", 32'(c_en), 32'(c < 2 || c == 7));
            chk("t4_dok", 32'(ic.data_ok), 32'(c >= 6));
            if (c == 6)
                chk("t4_rdata1", ic.rdata, 32'hA1);
            if (c == 7)
                chk("t4_rdata2", ic.rdata, 32'hA2);
        end
        for (int d = 0; d < 8; d++) begin
            tick();
            ic.req = 1'b0;
            c_rd = (d == 0) ? 32'hA3 : 32'h0;
            mid();
            chk("t4_drain_dok", 32'(ic.data_ok), 32'(d == 5));
            if (d == 5)
                chk("t4_rdata3", ic.rdata, 32'hA3);
        end

        // test 5: randomized traffic with stalls and delays
        for (int i = 0; i < 64; i++)
            refm[i] = 32'hC0DE_0000 | 32'(i);
        acc = 0;
        dok = 0;
        for (int cyc = 0; cyc < 30000 && acc < 2000; cyc++) begin
            tick();
            id.req = ($urandom_range(0, 3) != 0);
            id.wr = 1'($urandom_range(0, 1));
            id.size = 2'($urandom_range(0, 3));
            id.addr = $urandom;
            id.wdata = $urandom;
            mid();
            d_observe();
        end
        chk("t5_acc", 32'(acc), 32'd2000);
        for (int k = 0; k < 100 && expq.size() != 0; k++) begin
            tick();
            id.req = 1'b0;
            mid();
            d_observe();
        end
        chk("t5_balance", 32'(dok), 32'(acc));
        chk("t5_drained", 32'(expq.size()), 32'd0);

        // test 6: reset while two reads are in flight
        tick();
        ie.req = 1'b1; ie.addr = 32'h200; e_rd = 32'h0;
        mid();
        chk("t6_aok0", 32'(ie.addr_ok), 32'd1);
        tick();
        ie.addr = 32'h204; e_rd = 32'hE0;
        mid();
        chk("t6_aok1", 32'(ie.addr_ok), 32'd1);
        tick();
        rst = 1'b1;
        e_rd = 32'hE1;
        mid();
        chk("t6_rst_aok", 32'(ie.addr_ok), 32'd0);
        chk("t6_rst_dok", 32'(ie.data_ok), 32'd0);
        chk("t6_rst_en", 32'(e_en), 32'd0);
        chk("t6_rst_rdata", ie.rdata, 32'h0);
        tick();
        mid();
        chk("t6_rst_dok2", 32'(ie.data_ok), 32'd0);
        tick();
        rst = 1'b0;
        ie.req = 1'b0;
        e_rd = 32'h0;
        for (int c = 0; c < 8; c++) begin
            mid();
            chk("t6_ghost_dok", 32'(ie.data_ok), 32'd0);
            tick();
        end
        ie.req = 1'b1; ie.addr = 32'h300;
        mid();
        chk("t6_aok2", 32'(ie.addr_ok), 32'd1);
        for (int c = 1; c < 7; c++) begin
            tick();
            ie.req = 1'b0;
            e_rd = (c == 1) ? 32'hE5 : 32'h0;
            mid();
            chk("t6_dok", 32'(ie.data_ok), 32'(c == 5));
            if (c == 5)
                chk("t6_rdata", ie.rdata, 32'hE5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
